// File: rtl/dbn_neuron_sampler_if.sv
// Handshake and bus bundle between the PE array or controller and the neuron sampler.
interface dbn_neuron_sampler_if #(
  parameter int NUM_PE = 16,
  parameter int BW_PS  = 16
);
  logic                    start;
  logic [NUM_PE*BW_PS-1:0] ps_bus;
  logic [NUM_PE*BW_PS-1:0] bias_bus;
  logic                    det_mode;
  logic                    busy;
  logic                    out_valid;
  logic                    out_ready;
  logic [NUM_PE-1:0]       out_states;

  modport master (
    output start, ps_bus, bias_bus, det_mode, out_ready,
    input  busy, out_valid, out_states
  );
  modport slave (
    input  start, ps_bus, bias_bus, det_mode, out_ready,
    output busy, out_valid, out_states
  );
endinterface

// File: rtl/dbn_neuron_sampler.sv
// Snapshots PE partial sums, adds bias, applies a hard sigmoid and samples one
// binary neuron state per cycle against an LFSR, then hands the vector off.
module dbn_neuron_sampler #(
  parameter int          NUM_PE    = 16,
  parameter int          BW_PS     = 16,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  dbn_neuron_sampler_if.slave  s
);
  localparam int IW = (NUM_PE > 1) ? $clog2(NUM_PE) : 1;
  localparam logic signed [BW_PS:0] P_OFF = (BW_PS+1)'(512);
  localparam logic signed [BW_PS:0] P_MAX = (BW_PS+1)'(256);

  typedef enum logic [1:0] {ST_IDLE, ST_SAMPLE, ST_OUTPUT} state_t;

  state_t                  r_state, w_state_nxt;
  logic signed [BW_PS-1:0] r_ps   [NUM_PE];
  logic signed [BW_PS-1:0] r_bias [NUM_PE];
  logic                    r_det;
  logic [IW-1:0]           r_idx;
  logic [15:0]             r_lfsr;
  logic [NUM_PE-1:0]       r_states;

  logic                    w_capture, w_last, w_bit;
  logic [BW_PS:0]          w_sum_wide;
  logic signed [BW_PS-1:0] w_sum;
  logic signed [BW_PS:0]   w_off, w_shr;
  logic [8:0]              w_p;

  assign w_capture = (r_state == ST_IDLE) && s.start;
  assign w_last    = (r_idx == IW'(NUM_PE-1));

  // Sum at one extra bit so the saturation test is just a sign-bit compare.
  assign w_sum_wide = {r_ps[r_idx][BW_PS-1], r_ps[r_idx]}
                    + {r_bias[r_idx][BW_PS-1], r_bias[r_idx]};

  always_comb begin
    w_sum = w_sum_wide[BW_PS-1:0];
    if (w_sum_wide[BW_PS] != w_sum_wide[BW_PS-1])
      w_sum = w_sum_wide[BW_PS] ? {1'b1, {(BW_PS-1){1'b0}}} : {1'b0, {(BW_PS-1){1'b1}}};
  end

  // Hard sigmoid 0.25x+0.5 in 1/256 units, clamped to 0..256.
  assign w_off = {w_sum[BW_PS-1], w_sum} + P_OFF;
  assign w_shr = w_off >>> 2;

  always_comb begin
    w_p = w_shr[8:0];
    if (w_shr[BW_PS])       w_p = 9'd0;
    else if (w_shr > P_MAX) w_p = 9'd256;
  end

  assign w_bit = r_det ? (w_p >= 9'd128) : ({1'b0, r_lfsr[7:0]} < w_p);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:   if (s.start)     w_state_nxt = ST_SAMPLE;
      ST_SAMPLE: if (w_last)      w_state_nxt = ST_OUTPUT;
      ST_OUTPUT: if (s.out_ready) w_state_nxt = ST_IDLE;
      default:                    w_state_nxt = ST_IDLE;
    endcase
  end

  // Snapshot is mandatory: the PEs clear their sums once the phase moves on.
  always_ff @(posedge clk) begin
    if (w_capture) begin
      for (int i = 0; i < NUM_PE; i++) begin
        r_ps[i]   <= s.ps_bus[i*BW_PS +: BW_PS];
        r_bias[i] <= s.bias_bus[i*BW_PS +: BW_PS];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_det    <= 1'b0;
      r_idx    <= '0;
      r_lfsr   <= LFSR_SEED;
      r_states <= '0;
    end else if (w_capture) begin
      r_det <= s.det_mode;
      r_idx <= '0;
    end else if (r_state == ST_SAMPLE) begin
      r_states[r_idx] <= w_bit;
      r_idx           <= w_last ? '0 : r_idx + IW'(1);
      r_lfsr          <= {r_lfsr[14:0], r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10]};
    end
  end

  assign s.busy       = (r_state != ST_IDLE);
  assign s.out_valid  = (r_state == ST_OUTPUT);
  assign s.out_states = r_states;
endmodule

// File: tb/tb_dbn_neuron_sampler.sv
// Table-driven and randomized check of dbn_neuron_sampler against an arithmetic reference model.
module tb_dbn_neuron_sampler;
  localparam int          NP   = 4;
  localparam int          BW   = 16;
  localparam logic [15:0] SEED = 16'hACE1;
  localparam int          SMAX = 32767;
  localparam int          SMIN = -32768;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  dbn_neuron_sampler_if #(.NUM_PE(NP), .BW_PS(BW)) bus();
  dbn_neuron_sampler #(.NUM_PE(NP), .BW_PS(BW), .LFSR_SEED(SEED)) dut (
    .clk(clk), .rst_n(rst_n), .s(bus.slave)
  );

  int total = 0;
  int bad   = 0;
  logic [15:0] m_lfsr;

  typedef struct {
    int            ps[NP];
    int            bias[NP];
    bit            det;
    logic [NP-1:0] exp;
  } vec_t;
  vec_t vt[5];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  function automatic logic [15:0] lfsr_next(input logic [15:0] q);
    return {q[14:0], q[15] ^ q[13] ^ q[12] ^ q[10]};
  endfunction

  // Reference: saturate the integer sum, map to probability in 1/256, compare.
  task automatic model_phase(input int ps[NP], input int bias[NP], input bit det,
                             output logic [NP-1:0] e);
    int sm, p, r;
    for (int i = 0; i < NP; i++) begin
      sm = ps[i] + bias[i];
      if (sm > SMAX) sm = SMAX;
      if (sm < SMIN) sm = SMIN;
      p = (sm + 512) >>> 2;
      if (p < 0)   p = 0;
      if (p > 256) p = 256;
      r = int'(m_lfsr[7:0]);
      e[i] = det ? (p >= 128) : (r < p);
      m_lfsr = lfsr_next(m_lfsr);
    end
  endtask

  task automatic drive_bus(input int ps[NP], input int bias[NP], input bit det);
    logic [NP*BW-1:0] a, b;
    for (int i = 0; i < NP; i++) begin
      a[i*BW +: BW] = BW'(ps[i]);
      b[i*BW +: BW] = BW'(bias[i]);
    end
    bus.ps_bus   = a;
    bus.bias_bus = b;
    bus.det_mode = det;
  endtask

  task automatic rand_vals(output int a[NP]);
    for (int i = 0; i < NP; i++) a[i] = int'($urandom_range(0, 65535)) - 32768;
  endtask

  task automatic wait_valid(input string nm);
    int lat;
    lat = 1;
    while (!bus.out_valid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    chk({nm, " latency"}, lat, NP + 1);
  endtask

  // One phase with out_ready already high; start is accepted on the first edge.
  task automatic run_phase(input string nm, input int ps[NP], input int bias[NP],
                           input bit det, output logic [NP-1:0] got);
    logic [NP-1:0] e;
    @(negedge clk);
    drive_bus(ps, bias, det);
    bus.start = 1'b1;
    model_phase(ps, bias, det, e);
    @(negedge clk);
    bus.start = 1'b0;
    wait_valid(nm);
    chk({nm, " states"}, bus.out_states, e);
    got = bus.out_states;
    @(negedge clk);
    chk({nm, " released"}, {bus.busy, bus.out_valid}, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    int zp[NP];
    int rp[NP], rb[NP];
    logic [NP-1:0] got, e, hold;
    int ones;

    zp = '{default: 0};
    bus.start = 1'b0; bus.out_ready = 1'b1; bus.det_mode = 1'b0;
    bus.ps_bus = '0;  bus.bias_bus = '0;

    vt[0].ps = '{600, -600, 0, 100};          vt[0].bias = '{0, 0, 0, -300};
    vt[0].det = 1'b1; vt[0].exp = 4'b0101;
    vt[1].ps = '{-1, 0, 1, -512};             vt[1].bias = '{0, 0, 0, 0};
    vt[1].det = 1'b1; vt[1].exp = 4'b0110;
    vt[2].ps = '{32767, -32768, 20000, -20000}; vt[2].bias = '{100, -1, 20000, -20000};
    vt[2].det = 1'b1; vt[2].exp = 4'b0101;
    vt[3].ps = '{-513, 1000, -20000, 2};      vt[3].bias = '{0, -1000, 30000, -3};
    vt[3].det = 1'b1; vt[3].exp = 4'b0110;
    vt[4].ps = '{32767, -32768, 512, -512};   vt[4].bias = '{0, 0, 0, 0};
    vt[4].det = 1'b0; vt[4].exp = 4'b0101;

    // Reset held while start toggles
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("rst busy", bus.busy, 0);
      chk("rst out_valid", bus.out_valid, 0);
      chk("rst out_states", bus.out_states, 0);
      bus.start = ~bus.start;
    end
    bus.start = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    m_lfsr = SEED;

    // First sample after reset uses r=0xE1; hand-derived vector 4'b1000
    run_phase("first", zp, zp, 1'b0, got);
    chk("first seed vector", got, 4'b1000);

    foreach (vt[i]) begin
      run_phase($sformatf("vec%0d", i), vt[i].ps, vt[i].bias, vt[i].det, got);
      chk($sformatf("vec%0d table", i), got, vt[i].exp);
    end

    for (int k = 0; k < 50; k++) begin
      rand_vals(rp); rand_vals(rb);
      rp[0] = 32767;  rb[0] = 100;
      rp[1] = -32768; rb[1] = -1;
      run_phase("sat", rp, rb, 1'b0, got);
      chk("sat bit0", got[0], 1);
      chk("sat bit1", got[1], 0);
    end

    ones = 0;
    for (int k = 0; k < 64; k++) begin
      run_phase("zero", zp, zp, 1'b0, got);
      ones += $countones(got);
    end
    chk("ones count in 100..156", (ones >= 100 && ones <= 156), 1);

    for (int k = 0; k < 30; k++) begin
      rand_vals(rp); rand_vals(rb);
      for (int i = 0; i < NP; i++) begin
        rp[i] = rp[i] >>> ($urandom_range(0, 5));
        rb[i] = rb[i] >>> 6;
      end
      run_phase("rand", rp, rb, 1'(($urandom_range(0, 3)) == 0), got);
    end

    // Back-pressure: ignored starts while stalled, start accepted right after handshake
    bus.out_ready = 1'b0;
    rand_vals(rp); rand_vals(rb);
    @(negedge clk);
    drive_bus(rp, rb, 1'b0);
    bus.start = 1'b1;
    model_phase(rp, rb, 1'b0, e);
    @(negedge clk);
    bus.start = 1'b0;
    wait_valid("bp");
    chk("bp states", bus.out_states, e);
    hold = e;
    for (int k = 0; k < 6; k++) begin
      rand_vals(rp);
      drive_bus(rp, rp, 1'b1);
      bus.start = (k == 1 || k == 3);
      @(negedge clk);
      chk("bp hold valid", bus.out_valid, 1);
      chk("bp hold busy", bus.busy, 1);
      chk("bp hold states", bus.out_states, hold);
    end
    bus.out_ready = 1'b1;
    bus.start = 1'b1;
    @(negedge clk);
    chk("bp handshake", {bus.busy, bus.out_valid}, 0);
    rand_vals(rp); rand_vals(rb);
    drive_bus(rp, rb, 1'b0);
    model_phase(rp, rb, 1'b0, e);
    @(negedge clk);
    bus.start = 1'b0;
    chk("bp restart busy", bus.busy, 1);
    wait_valid("bp2");
    chk("bp2 states", bus.out_states, e);
    @(negedge clk);

    // Reset mid-SAMPLE: phase aborted, LFSR back to seed
    @(negedge clk);
    drive_bus(zp, zp, 1'b0);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst busy", bus.busy, 0);
    chk("midrst out_valid", bus.out_valid, 0);
    @(negedge clk);
    rst_n = 1'b1;
    m_lfsr = SEED;
    run_phase("after rst", zp, zp, 1'b0, got);
    chk("after rst seed vector", got, 4'b1000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
